mdu_hilo_unit: RTL and testbench
================================

Name: mdu_hilo_unit

Overview:
- Execute-stage multiply/divide responder for the HILO operations flagged at decode.
- Executes mult/multu/div/divu over several cycles and owns the HI/LO registers.
- Serves mthi/mtlo/mfhi/mflo.
- Drives the stall request that holds later HILO instructions in D while an operation is in flight.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- E_HILO_op  input  4  operation in E: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo, others = none
- E_RD1  input  32  forwarded rs value
- E_RD2  input  32  forwarded rt value
- D_HILO_operation  input  1  instruction in D is any HILO instruction
- start  output  1  combinational; high when E_HILO_op is 1..4 and busy=0
- busy  output  1  registered; high while an operation is in progress
- HILO_out  output  32  combinational; HI when op=7, LO when op=8, else 0
- HILO_stall  output  1  combinational; D_HILO_operation & (start | busy)

Behaviour:
- Reset (reset=0, async): HI=0, LO=0, busy=0, cnt=0, temp_hi=0, temp_lo=0. Outputs follow from these values: start=0 unless op present, HILO_out per op.
- Issue, on the edge of a cycle with start=1:
  - latch result into temp_hi/temp_lo
  - cnt←MULT_CYCLES for ops 1/2, cnt←DIV_CYCLES for ops 3/4
  - busy←1
- Busy countdown, each edge with busy=1:
  - cnt←cnt-1
  - when cnt==1: HI←temp_hi, LO←temp_lo, busy←0, cnt←0
- Latency: op issued in cycle t ⇒ busy high for cycles t+1..t+N. New HI/LO are visible to mfhi/mflo in cycle t+N+1.
- mult: {temp_hi,temp_lo} = signed E_RD1 × signed E_RD2 (64-bit).
- multu: {temp_hi,temp_lo} = unsigned 64-bit product.
- div: temp_lo = signed quotient truncated toward zero; temp_hi = remainder with the sign of the dividend.
- divu: unsigned quotient to temp_lo, unsigned remainder to temp_hi.
- Divisor == 0 (div/divu): full busy period still runs. HI/LO are left unchanged at completion.
- 0x80000000 div 0xFFFFFFFF: LO=0x80000000, HI=0.
- mthi: HI←E_RD1 at the edge; applies only when busy=0.
- mtlo: LO←E_RD1 at the edge; applies only when busy=0.
- mthi/mtlo with busy=1: ignored. The hazard logic guarantees this cannot happen; an assertion in the bench checks it.
- E_HILO_op 1..4 while busy=1: ignored, with no restart and no temp overwrite. Same guarantee.
- mfhi/mflo read the current HI/LO registers. There is no bypass from temp registers or from same-cycle mthi/mtlo.
- Stall: any HILO instruction in D stalls while start or busy is high. It issues in the cycle after busy falls.
- Non-HILO instructions never stall.
- Reset asserted mid-operation: the operation is abandoned. busy→0 and HI/LO→0 immediately, with no write-back after release.
- Width rules: all products and quotients are computed on 32-bit operands. Sign/zero extension to 64 bits is chosen by op.

Test Plan:
- Reset then mfhi/mflo: reset low 2 cycles → busy=0, HILO_out=0 for op 7 and op 8.
- mult, signed: E_RD1=0xFFFFFFFE (-2), E_RD2=3 → start=1 one cycle, busy high exactly 5 cycles. Afterwards HI=0xFFFFFFFF, LO=0xFFFFFFFA. multu on the same operands gives HI=0x00000002, LO=0xFFFFFFFA.
- div signed: E_RD1=-7, E_RD2=2 → busy 10 cycles, then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). divu 7/2 gives LO=3, HI=1. divu x/0 leaves HI/LO at prior values.
- Stall timing: mult issued with D_HILO_operation=1 (mflo) → HILO_stall=1 for the issue cycle plus 5 busy cycles, 0 on the next cycle. That mflo then returns the new LO.
- mthi/mtlo: mthi 0x12345678 then mtlo 0x9ABCDEF0 on consecutive cycles → mfhi/mflo return those values. A D-stage add (D_HILO_operation=0) during busy gives HILO_stall=0.
- Async reset mid-div: reset dropped at busy cycle 4 between edges → busy=0 and HI=LO=0 without a clock edge. After release there is no late write-back and no stall.

Source files
------------

// File: rtl/mdu_hilo_unit.sv
// mdu_hilo_unit
// Execute-stage multiply/divide unit that owns the HI/LO registers.
// mult, multu, div and divu run over a fixed number of busy cycles. The
// result is captured into temporaries at issue and committed to HI/LO when
// the countdown ends. mthi and mtlo write HI/LO directly. mfhi and mflo read
// HI/LO combinationally. The stall output holds any HILO instruction in D
// while an operation is issuing or in flight.
//
// Ports:
//   clk              in   system clock, rising edge
//   reset            in   asynchronous reset, active low
//   E_HILO_op[3:0]   in   op in E: 1 mult, 2 multu, 3 div, 4 divu,
//                         5 mthi, 6 mtlo, 7 mfhi, 8 mflo, other = none
//   E_RD1[31:0]      in   rs operand (dividend / mthi-mtlo source)
//   E_RD2[31:0]      in   rt operand (divisor)
//   D_HILO_operation in   instruction in D is a HILO instruction
//   start            out  mult/div accepted this cycle (combinational)
//   busy             out  operation in flight (registered)
//   HILO_out[31:0]   out  HI for mfhi, LO for mflo, else 0
//   HILO_stall       out  stall request for D
module mdu_hilo_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_HILO_op,
    input  logic [31:0] E_RD1,
    input  logic [31:0] E_RD2,
    input  logic        D_HILO_operation,
    output logic        start,
    output logic        busy,
    output logic [31:0] HILO_out,
    output logic        HILO_stall
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic [31:0]      hi_q, hi_d, lo_q, lo_d;
    logic [31:0]      temp_hi_q, temp_hi_d, temp_lo_q, temp_lo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    // Cleared for a divide by zero so completion leaves HI/LO untouched.
    logic             wb_q, wb_d;

    // Arithmetic datapath, evaluated on the E operands every cycle.
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic signed [31:0] dvd_s, dvs_s, quo_s, rem_s;
    logic        [31:0] dvs_u, quo_u, rem_u;
    logic               div_zero, div_ovf;

    assign prod_s = $signed({{32{E_RD1[31]}}, E_RD1}) * $signed({{32{E_RD2[31]}}, E_RD2});
    assign prod_u = {32'd0, E_RD1} * {32'd0, E_RD2};

    assign div_zero = (E_RD2 == 32'd0);
    // INT_MIN / -1 overflows a 32-bit quotient; the defined answer is
    // quotient INT_MIN, remainder 0.
    assign div_ovf  = (E_RD1 == 32'h8000_0000) && (E_RD2 == 32'hFFFF_FFFF);

    // A divisor of 1 stands in for 0 so the dividers never see a zero; the
    // result is discarded anyway.
    assign dvd_s = $signed(E_RD1);
    assign dvs_s = div_zero ? 32'sd1 : $signed(E_RD2);
    assign dvs_u = div_zero ? 32'd1 : E_RD2;
    assign quo_s = div_ovf ? 32'sh8000_0000 : (dvd_s / dvs_s);
    assign rem_s = div_ovf ? 32'sd0 : (dvd_s % dvs_s);
    assign quo_u = E_RD1 / dvs_u;
    assign rem_u = E_RD1 % dvs_u;

    assign start      = (E_HILO_op >= OP_MULT) && (E_HILO_op <= OP_DIVU) && !busy_q;
    assign busy       = busy_q;
    assign HILO_stall = D_HILO_operation && (start || busy_q);

    always_comb begin
        HILO_out = 32'd0;
        if (E_HILO_op == OP_MFHI) HILO_out = hi_q;
        else if (E_HILO_op == OP_MFLO) HILO_out = lo_q;
    end

    always_comb begin
        hi_d      = hi_q;
        lo_d      = lo_q;
        temp_hi_d = temp_hi_q;
        temp_lo_d = temp_lo_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        wb_d      = wb_q;
        if (busy_q) begin
            // New ops and mthi/mtlo are ignored while busy.
            if (cnt_q == CNT_W'(1)) begin
                busy_d = 1'b0;
                cnt_d  = '0;
                if (wb_q) begin
                    hi_d = temp_hi_q;
                    lo_d = temp_lo_q;
                end
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end else begin
            case (E_HILO_op)
                OP_MULT: begin
                    {temp_hi_d, temp_lo_d} = prod_s;
                    cnt_d  = CNT_W'(MULT_CYCLES);
                    busy_d = 1'b1;
                    wb_d   = 1'b1;
                end
                OP_MULTU: begin
                    {temp_hi_d, temp_lo_d} = prod_u;
                    cnt_d  = CNT_W'(MULT_CYCLES);
                    busy_d = 1'b1;
                    wb_d   = 1'b1;
                end
                OP_DIV: begin
                    temp_hi_d = rem_s;
                    temp_lo_d = quo_s;
                    cnt_d     = CNT_W'(DIV_CYCLES);
                    busy_d    = 1'b1;
                    wb_d      = !div_zero;
                end
                OP_DIVU: begin
                    temp_hi_d = rem_u;
                    temp_lo_d = quo_u;
                    cnt_d     = CNT_W'(DIV_CYCLES);
                    busy_d    = 1'b1;
                    wb_d      = !div_zero;
                end
                OP_MTHI: hi_d = E_RD1;
                OP_MTLO: lo_d = E_RD1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q      <= '0;
            lo_q      <= '0;
            temp_hi_q <= '0;
            temp_lo_q <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            wb_q      <= 1'b0;
        end else begin
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            temp_hi_q <= temp_hi_d;
            temp_lo_q <= temp_lo_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            wb_q      <= wb_d;
        end
    end

endmodule

// File: tb/tb_mdu_hilo_unit.sv
// Testbench for mdu_hilo_unit: directed scenarios plus randomized mult/div
// and mthi/mtlo traffic checked against an arithmetic reference model.
module tb_mdu_hilo_unit;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk;
    logic        reset;
    logic [3:0]  E_HILO_op;
    logic [31:0] E_RD1, E_RD2;
    logic        D_HILO_operation;
    logic        start, busy, HILO_stall;
    logic [31:0] HILO_out;

    int checks = 0;
    int errors = 0;

    // Reference HI/LO as the architecture should see them.
    logic [31:0] ref_hi, ref_lo;

    mdu_hilo_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset(reset), .E_HILO_op(E_HILO_op), .E_RD1(E_RD1),
        .E_RD2(E_RD2), .D_HILO_operation(D_HILO_operation), .start(start),
        .busy(busy), .HILO_out(HILO_out), .HILO_stall(HILO_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The stimulus must never present an op or mthi/mtlo while busy.
    always @(posedge clk) begin
        if (reset && busy && (E_HILO_op >= 4'd1) && (E_HILO_op <= 4'd6))
            $error("hazard violated: op %0d presented while busy", E_HILO_op);
    end

    // Reference model: results from plain signed/unsigned 64-bit arithmetic.
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint la, lb, mq, q, r;
        logic [63:0] p;
        case (op)
            4'd1: begin
                la = longint'($signed(a)); lb = longint'($signed(b));
                p = la * lb; ref_hi = p[63:32]; ref_lo = p[31:0];
            end
            4'd2: begin
                la = longint'(a); lb = longint'(b);
                p = la * lb; ref_hi = p[63:32]; ref_lo = p[31:0];
            end
            4'd3: if (b != 0) begin
                la = longint'($signed(a)); lb = longint'($signed(b));
                mq = (la < 0 ? -la : la) / (lb < 0 ? -lb : lb);
                q  = ((la < 0) != (lb < 0)) ? -mq : mq;
                r  = la - q * lb;
                ref_lo = q[31:0]; ref_hi = r[31:0];
            end
            4'd4: if (b != 0) begin ref_lo = a / b; ref_hi = a % b; end
            4'd5: ref_hi = a;
            4'd6: ref_lo = a;
            default: ;
        endcase
    endtask

    // Present one op for a single cycle, report start, then count busy cycles.
    // Returns on the negedge after busy falls.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic st, output int nbusy);
        @(negedge clk);
        E_HILO_op = op; E_RD1 = a; E_RD2 = b;
        #1 st = start;
        @(negedge clk);
        E_HILO_op = 4'd0;
        nbusy = 0;
        while (busy === 1'b1 && nbusy < 100) begin
            nbusy++;
            @(negedge clk);
        end
    endtask

    // Combinational read of HI (op 7) or LO (op 8) within the low phase.
    task automatic rd(input logic [3:0] op, output logic [31:0] v);
        E_HILO_op = op;
        #1 v = HILO_out;
        E_HILO_op = 4'd0;
    endtask

    task automatic test_reset;
        logic [31:0] v;
        reset = 1'b0; E_HILO_op = 0; E_RD1 = 0; E_RD2 = 0; D_HILO_operation = 0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        checks++; if (start !== 1'b0) begin errors++; $display("FAIL reset_start got %0b want 0", start); end
        rd(4'd7, v);
        checks++; if (v !== 32'd0) begin errors++; $display("FAIL reset_hi got %h want 0", v); end
        rd(4'd8, v);
        checks++; if (v !== 32'd0) begin errors++; $display("FAIL reset_lo got %h want 0", v); end
        reset = 1'b1;
        ref_hi = 0; ref_lo = 0;
        $display("reset: hi/lo cleared");
    endtask

    task automatic test_mult;
        logic st; int nb; logic [31:0] h, l;
        issue(4'd1, 32'hFFFF_FFFE, 32'd3, st, nb);
        rd(4'd7, h); rd(4'd8, l);
        checks++; if (st !== 1'b1) begin errors++; $display("FAIL mult_start got %0b want 1", st); end
        checks++; if (nb != MULT_N) begin errors++; $display("FAIL mult_busy got %0d want %0d", nb, MULT_N); end
        checks++; if (h !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got %h want ffffffff", h); end
        checks++; if (l !== 32'hFFFF_FFFA) begin errors++; $display("FAIL mult_lo got %h want fffffffa", l); end
        $display("mult -2*3: hi=%h lo=%h busy=%0d", h, l, nb);
        issue(4'd2, 32'hFFFF_FFFE, 32'd3, st, nb);
        rd(4'd7, h); rd(4'd8, l);
        checks++; if (h !== 32'h0000_0002) begin errors++; $display("FAIL multu_hi got %h want 00000002", h); end
        checks++; if (l !== 32'hFFFF_FFFA) begin errors++; $display("FAIL multu_lo got %h want fffffffa", l); end
        $display("multu: hi=%h lo=%h busy=%0d", h, l, nb);
        ref_hi = 32'h2; ref_lo = 32'hFFFF_FFFA;
    endtask

    task automatic test_div;
        logic st; int nb; logic [31:0] h, l;
        issue(4'd3, 32'hFFFF_FFF9, 32'd2, st, nb);
        rd(4'd7, h); rd(4'd8, l);
        checks++; if (nb != DIV_N) begin errors++; $display("FAIL div_busy got %0d want %0d", nb, DIV_N); end
        checks++; if (l !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo got %h want fffffffd", l); end
        checks++; if (h !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi got %h want ffffffff", h); end
        $display("div -7/2: hi=%h lo=%h busy=%0d", h, l, nb);
        issue(4'd4, 32'd7, 32'd2, st, nb);
        rd(4'd7, h); rd(4'd8, l);
        checks++; if (l !== 32'd3 || h !== 32'd1) begin errors++; $display("FAIL divu_res got hi=%h lo=%h want hi=1 lo=3", h, l); end
        $display("divu 7/2: hi=%h lo=%h", h, l);
        issue(4'd4, 32'd1234, 32'd0, st, nb);
        rd(4'd7, h); rd(4'd8, l);
        checks++; if (nb != DIV_N) begin errors++; $display("FAIL divz_busy got %0d want %0d", nb, DIV_N); end
        checks++; if (l !== 32'd3 || h !== 32'd1) begin errors++; $display("FAIL divz_keep got hi=%h lo=%h want hi=1 lo=3", h, l); end
        $display("divu x/0: hi=%h lo=%h", h, l);
        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, st, nb);
        rd(4'd7, h); rd(4'd8, l);
        checks++; if (l !== 32'h8000_0000 || h !== 32'd0) begin errors++; $display("FAIL div_ovf got hi=%h lo=%h want hi=0 lo=80000000", h, l); end
        $display("div min/-1: hi=%h lo=%h", h, l);
        ref_hi = 0; ref_lo = 32'h8000_0000;
    endtask

    task automatic test_stall;
        int n; logic [31:0] l;
        @(negedge clk);
        E_HILO_op = 4'd1; E_RD1 = 32'd1000; E_RD2 = 32'd77; D_HILO_operation = 1'b1;
        model(4'd1, 32'd1000, 32'd77);
        #1 n = 0;
        while (HILO_stall === 1'b1 && n < 50) begin
            n++;
            @(negedge clk);
            E_HILO_op = 4'd0;
            #1;
        end
        checks++; if (n != MULT_N + 1) begin errors++; $display("FAIL stall_len got %0d want %0d", n, MULT_N + 1); end
        D_HILO_operation = 1'b0;
        rd(4'd8, l);
        checks++; if (l !== ref_lo) begin errors++; $display("FAIL stall_mflo got %h want %h", l, ref_lo); end
        $display("stall: cycles=%0d mflo=%h", n, l);
    endtask

    task automatic test_mthi_mtlo;
        logic [31:0] h, l; logic s;
        @(negedge clk); E_HILO_op = 4'd5; E_RD1 = 32'h1234_5678;
        @(negedge clk); E_HILO_op = 4'd6; E_RD1 = 32'h9ABC_DEF0;
        @(negedge clk); E_HILO_op = 4'd0;
        rd(4'd7, h); rd(4'd8, l);
        checks++; if (h !== 32'h1234_5678) begin errors++; $display("FAIL mthi got %h want 12345678", h); end
        checks++; if (l !== 32'h9ABC_DEF0) begin errors++; $display("FAIL mtlo got %h want 9abcdef0", l); end
        $display("mthi/mtlo: hi=%h lo=%h", h, l);
        // Non-HILO instruction in D during busy must not stall.
        @(negedge clk); E_HILO_op = 4'd2; E_RD1 = 32'd5; E_RD2 = 32'd6; D_HILO_operation = 1'b0;
        @(negedge clk); E_HILO_op = 4'd0;
        #1 s = HILO_stall;
        checks++; if (busy !== 1'b1 || s !== 1'b0) begin errors++; $display("FAIL nohilo_stall got busy=%0b stall=%0b want busy=1 stall=0", busy, s); end
        while (busy === 1'b1) @(negedge clk);
        ref_hi = 0; ref_lo = 32'd30;
        $display("non-HILO in D during busy: stall=%0b", s);
    endtask

    task automatic test_async_reset;
        int k; logic [31:0] h, l;
        @(negedge clk); E_HILO_op = 4'd5; E_RD1 = 32'h5555_AAAA;
        @(negedge clk); E_HILO_op = 4'd3; E_RD1 = 32'd100; E_RD2 = 32'd7;
        @(negedge clk); E_HILO_op = 4'd0;
        k = 1;
        while (k < 4) begin @(negedge clk); k++; end
        #2 reset = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy got %0b want 0", busy); end
        rd(4'd7, h); rd(4'd8, l);
        checks++; if (h !== 32'd0 || l !== 32'd0) begin errors++; $display("FAIL arst_hilo got hi=%h lo=%h want 0", h, l); end
        @(negedge clk); reset = 1'b1;
        repeat (DIV_N + 3) @(negedge clk);
        D_HILO_operation = 1'b1;
        rd(4'd7, h); rd(4'd8, l);
        checks++; if (h !== 32'd0 || l !== 32'd0) begin errors++; $display("FAIL arst_late_wb got hi=%h lo=%h want 0", h, l); end
        checks++; if (HILO_stall !== 1'b0) begin errors++; $display("FAIL arst_stall got %0b want 0", HILO_stall); end
        D_HILO_operation = 1'b0;
        ref_hi = 0; ref_lo = 0;
        $display("async reset mid-div: hi=%h lo=%h", h, l);
    endtask

    task automatic test_random;
        logic [3:0] op; logic [31:0] a, b, h, l; logic st; int nb, want_nb;
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(1, 6));
            a  = $urandom;
            b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) b = b & 32'h0000_00FF;
            if (op <= 4'd4) begin
                want_nb = (op <= 4'd2) ? MULT_N : DIV_N;
                issue(op, a, b, st, nb);
                checks++; if (nb != want_nb || st !== 1'b1) begin errors++; $display("FAIL rnd_busy[%0d] got start=%0b busy=%0d want 1/%0d", i, st, nb, want_nb); end
            end else begin
                @(negedge clk); E_HILO_op = op; E_RD1 = a; E_RD2 = b;
                @(negedge clk); E_HILO_op = 4'd0;
            end
            model(op, a, b);
            rd(4'd7, h); rd(4'd8, l);
            checks++; if (h !== ref_hi || l !== ref_lo) begin errors++; $display("FAIL rnd_hilo[%0d] op=%0d a=%h b=%h got hi=%h lo=%h want hi=%h lo=%h", i, op, a, b, h, l, ref_hi, ref_lo); end
            $display("rnd %0d: op=%0d a=%h b=%h hi=%h lo=%h", i, op, a, b, h, l);
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_stall();
        test_mthi_mtlo();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
